mem_mp_tagged: RTL and testbench
================================

Name: mem_mp_tagged

Overview:
- Parametrised multi-port successor to the single-port tagged memory model that feeds IM and DM in the processor bench.
- Holds one shared word array. NUM_PORTS requesters contend for it through a round-robin arbiter.
- Each accepted request is acknowledged with a per-port tag. Load data returns exactly LATENCY cycles later, marked by that tag.
- Lets IM and DM (or more requesters) share one memory image with configurable latency.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8).
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width (multiple of 8).
- TAG_W, 4, tag width. Tag 0 means "no tag".
- DEPTH_WORDS, 16384, array depth (power of two).
- LATENCY, 4, cycles from grant edge to load-data return (1..2^TAG_W-2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- proc2mem_command  in  2*NUM_PORTS  per port: 0 NONE, 1 LOAD, 2 STORE, 3 reserved (treated as NONE).
- proc2mem_addr  in  ADDR_W*NUM_PORTS  per-port byte address.
- proc2mem_data  in  DATA_W*NUM_PORTS  per-port store data.
- mem2proc_response  out  TAG_W*NUM_PORTS  per-port acceptance tag, combinational, same cycle as request.
- mem2proc_data  out  DATA_W*NUM_PORTS  per-port load return data, registered.
- mem2proc_tag  out  TAG_W*NUM_PORTS  per-port return tag, registered. Nonzero for one cycle only.

Behaviour:
- Array: unified_memory[DEPTH_WORDS], indexed by addr[log2(DEPTH_WORDS)+1:2].
  - addr[1:0] ignored; upper bits wrap (modulo).
  - No reset on contents. Contents survive rst and are loadable via hierarchical $readmemh.
- Arbitration: one grant per cycle.
  - Requesting ports are those with command 1 or 2.
  - Grant goes to the first requester at or after rr_ptr, scanning upward with wrap.
  - On a grant, rr_ptr <= grant+1 mod NUM_PORTS. With no request, rr_ptr holds.
- Response:
  - mem2proc_response[p] = next_tag[p] when p is granted this cycle, else 0.
  - Requester must hold its request until it sees a nonzero response. A zero response is a stall, not an error.
- Tags: per-port next_tag, reset to 1.
  - Increments on each grant to that port (loads and stores).
  - Wraps 2^TAG_W-1 -> 1, skipping 0.
  - Tags in flight never alias because LATENCY < 2^TAG_W-1.
- Store: array written at the grant edge. No tag return on mem2proc_tag.
- Load:
  - Array read at the grant edge into a LATENCY-deep pipeline entry holding {valid, port, tag, data}.
  - After LATENCY rising edges, mem2proc_tag[port]=tag and mem2proc_data[port]=data for exactly one cycle.
  - Otherwise mem2proc_tag=0 and mem2proc_data=0.
- Ordering: grants are serialised on one array.
  - A load granted after a store to the same word returns the new data, even in the next cycle.
  - Returns for one port arrive in grant order.
  - At most one return per cycle across all ports.
- Reset (rst=0, asynchronous, at any time):
  - Pipeline valids cleared; in-flight loads are dropped and never returned.
  - rr_ptr=0; all next_tag=1; all mem2proc_tag=0; all mem2proc_data=0.
  - mem2proc_response=0 while rst=0.
  - After rst deassert, the first grant goes to the lowest-index requester.
- Simultaneous requests from all ports: each port is granted exactly once every NUM_PORTS cycles. No starvation.

Optional Feature:
- MEM_BYTE_WRITE_EN defined:
  - Adds input proc2mem_be, (DATA_W/8)*NUM_PORTS wide.
  - A store writes only the byte lanes whose be bit is 1.
  - be=0 on a store still consumes a grant and a tag, but leaves the word unchanged.
- Not defined: no be port; stores always write the full word.
- Loads are unaffected in both cases.

Test Plan:
1. Reset then single load: memory preloaded word 0x40 = 0xDEADBEEF. Port0 LOAD addr 0x100 at cycle 0 -> response0=1 at cycle 0; tag0=1, data0=0xDEADBEEF at cycle LATENCY(4); tag0=0 afterwards.
2. Contention: both ports LOAD continuously for 6 cycles from rr_ptr=0 -> grants alternate P0,P1,P0,P1,P0,P1. Each port sees tags 1,2,3. Stalled cycles show response=0.
3. RAW: P1 STORE 0x12345678 to 0x200 at cycle 0, P1 LOAD 0x200 at cycle 1 -> return data 0x12345678 with tag 2 at cycle 5.
4. Tag wrap: 16 consecutive P0 loads (TAG_W=4) -> tags 1..15 then 1. Tag 0 is never issued.
5. Reset mid-flight: 3 loads outstanding, rst low for 1 cycle -> no tag returns afterwards; next grant tag=1, rr_ptr=0.
6. With MEM_BYTE_WRITE_EN: word 0xAABBCCDD, STORE 0x11223344 be=4'b0101 -> load returns 0xAA22CC44.

Source files
------------

// File: rtl/mem_mp_tagged_if.sv
// mem_mp_tagged_if: request/return bus between NUM_PORTS requesters and the
// shared tagged memory. All per-port fields are flattened, port p occupying
// slice [p*W +: W] of each vector.
//   proc2mem_command  : 2 bits/port, 0 NONE, 1 LOAD, 2 STORE, 3 reserved (NONE)
//   proc2mem_addr     : ADDR_W bits/port, byte address
//   proc2mem_data     : DATA_W bits/port, store data
//   proc2mem_be       : DATA_W/8 bits/port, store byte enables
//                       (only when MEM_BYTE_WRITE_EN is defined)
//   mem2proc_response : TAG_W bits/port, acceptance tag, 0 = stall
//   mem2proc_data     : DATA_W bits/port, load return data
//   mem2proc_tag      : TAG_W bits/port, load return tag, 0 = no return
// Optional macro: MEM_BYTE_WRITE_EN adds proc2mem_be.
interface mem_mp_tagged_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4
);
  logic [2*NUM_PORTS-1:0]      proc2mem_command;
  logic [ADDR_W*NUM_PORTS-1:0] proc2mem_addr;
  logic [DATA_W*NUM_PORTS-1:0] proc2mem_data;
`ifdef MEM_BYTE_WRITE_EN
  logic [(DATA_W/8)*NUM_PORTS-1:0] proc2mem_be;
`endif
  logic [TAG_W*NUM_PORTS-1:0]  mem2proc_response;
  logic [DATA_W*NUM_PORTS-1:0] mem2proc_data;
  logic [TAG_W*NUM_PORTS-1:0]  mem2proc_tag;

`ifdef MEM_BYTE_WRITE_EN
  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_be,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );
  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_be,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
`else
  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );
  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
`endif
endinterface

// File: rtl/mem_mp_tagged.sv
// mem_mp_tagged: multi-port tagged memory model. NUM_PORTS requesters share a
// single word array through a round-robin arbiter (one grant per cycle).
// A granted request is acknowledged combinationally with that port's next
// tag; a granted load returns its data with the same tag exactly LATENCY
// cycles after the grant edge. Stores write at the grant edge, no return.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (array contents are not reset)
//   bus  : mem_mp_tagged_if.slave (command/addr/data in, response/data/tag out)
// Optional macro: MEM_BYTE_WRITE_EN enables per-byte store enables
// (bus.proc2mem_be); without it stores write the full word.
module mem_mp_tagged #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 4,
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4
) (
  input logic            clk,
  input logic            rst,
  mem_mp_tagged_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BE_W  = DATA_W / 8;
  localparam int LAST  = LATENCY - 1;

  localparam logic [TAG_W-1:0] TAG_MAX   = '1;
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
  localparam logic [1:0]       CMD_LOAD  = 2'd1;
  localparam logic [1:0]       CMD_STORE = 2'd2;

  // Per-port unpacked views of the flattened bus
  logic [1:0]        cmd      [NUM_PORTS];
  logic [IDX_W-1:0]  addr_idx [NUM_PORTS];
  logic [DATA_W-1:0] wdata    [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
`ifdef MEM_BYTE_WRITE_EN
  logic [BE_W-1:0]   be       [NUM_PORTS];
  logic [BE_W-1:0]   gnt_be;
`endif

  // Arbitration / tag state
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [TAG_W-1:0] next_tag_reg [NUM_PORTS];
  logic             grant_any;
  logic             grant_valid;
  logic [PTR_W-1:0] grant_port;

  // Granted request
  logic [1:0]        gnt_cmd;
  logic [IDX_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_wdata;
  logic [TAG_W-1:0]  gnt_tag;
  logic              is_load;
  logic              is_store;

  // Storage and load-return pipeline
  logic [DATA_W-1:0] unified_memory [DEPTH_WORDS];
  logic              pipe_valid_reg [LATENCY];
  logic [PTR_W-1:0]  pipe_port_reg  [LATENCY];
  logic [TAG_W-1:0]  pipe_tag_reg   [LATENCY];
  logic [DATA_W-1:0] pipe_data_reg  [LATENCY];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_in
      logic unused_addr_lo;
      assign cmd[gi]      = bus.proc2mem_command[2*gi +: 2];
      assign addr_idx[gi] = bus.proc2mem_addr[gi*ADDR_W + 2 +: IDX_W];
      assign wdata[gi]    = bus.proc2mem_data[gi*DATA_W +: DATA_W];
      assign req[gi]      = (cmd[gi] == CMD_LOAD) || (cmd[gi] == CMD_STORE);
`ifdef MEM_BYTE_WRITE_EN
      assign be[gi]       = bus.proc2mem_be[gi*BE_W +: BE_W];
`endif
      // Byte offset and bits above the word index do not select storage:
      // addresses wrap modulo the array size.
      assign unused_addr_lo = ^bus.proc2mem_addr[gi*ADDR_W +: 2];
      if (ADDR_W > IDX_W + 2) begin : g_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.proc2mem_addr[gi*ADDR_W + IDX_W + 2 +: ADDR_W - IDX_W - 2];
      end
    end
  endgenerate

  // Round-robin: first requester at or after rr_ptr, scanning upward with
  // wrap. Nothing is granted while reset is asserted.
  always_comb begin : arbiter
    logic [PTR_W:0] cand;
    grant_any  = 1'b0;
    grant_port = '0;
    cand       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!grant_any && req[cand[PTR_W-1:0]]) begin
        grant_any  = 1'b1;
        grant_port = cand[PTR_W-1:0];
      end
    end
    grant_valid = grant_any & rst;
  end

  always_comb begin
    gnt_cmd   = cmd[grant_port];
    gnt_idx   = addr_idx[grant_port];
    gnt_wdata = wdata[grant_port];
    gnt_tag   = next_tag_reg[grant_port];
`ifdef MEM_BYTE_WRITE_EN
    gnt_be    = be[grant_port];
`endif
    is_load   = grant_valid && (gnt_cmd == CMD_LOAD);
    is_store  = grant_valid && (gnt_cmd == CMD_STORE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_valid) begin
      if (grant_port == PTR_W'(NUM_PORTS - 1)) rr_ptr_reg <= '0;
      else                                     rr_ptr_reg <= grant_port + 1'b1;
    end
  end

  // Tags count 1..TAG_MAX and skip 0, which means "no tag" on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PORTS; p++) next_tag_reg[p] <= TAG_FIRST;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant_valid && (grant_port == PTR_W'(p))) begin
          next_tag_reg[p] <= (next_tag_reg[p] == TAG_MAX) ? TAG_FIRST
                                                          : next_tag_reg[p] + 1'b1;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign bus.mem2proc_response[gi*TAG_W +: TAG_W] =
        (grant_valid && (grant_port == PTR_W'(gi))) ? next_tag_reg[gi] : '0;
    end
  endgenerate

  // Array write port. Only one grant per cycle, so a load is never granted
  // in the same cycle as a store; a load in the following cycle sees it.
`ifdef MEM_BYTE_WRITE_EN
  always_ff @(posedge clk) begin
    if (is_store) begin
      for (int b = 0; b < BE_W; b++) begin
        if (gnt_be[b]) unified_memory[gnt_idx][b*8 +: 8] <= gnt_wdata[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (is_store) unified_memory[gnt_idx] <= gnt_wdata;
  end
`endif

  // Registered array read lands in stage 0 of the data pipeline; data stages
  // carry no reset because the returned value is qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (is_load) pipe_data_reg[0] <= unified_memory[gnt_idx];
    for (int k = 1; k < LATENCY; k++) pipe_data_reg[k] <= pipe_data_reg[k-1];
  end

  // Control pipeline: reset drops every in-flight load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_valid_reg[k] <= 1'b0;
        pipe_port_reg[k]  <= '0;
        pipe_tag_reg[k]   <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= is_load;
      pipe_port_reg[0]  <= grant_port;
      pipe_tag_reg[0]   <= gnt_tag;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
        pipe_port_reg[k]  <= pipe_port_reg[k-1];
        pipe_tag_reg[k]   <= pipe_tag_reg[k-1];
      end
    end
  end

  // Returns come straight from the last pipeline stage (register outputs,
  // steered to the owning port), so they appear LATENCY edges after the
  // grant and last exactly one cycle.
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ret
      logic ret_hit;
      assign ret_hit = pipe_valid_reg[LAST] && (pipe_port_reg[LAST] == PTR_W'(gi));
      assign bus.mem2proc_tag[gi*TAG_W +: TAG_W]    = ret_hit ? pipe_tag_reg[LAST]  : '0;
      assign bus.mem2proc_data[gi*DATA_W +: DATA_W] = ret_hit ? pipe_data_reg[LAST] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_mp_tagged.sv
// tb_mem_mp_tagged: directed scenarios plus randomized traffic for
// mem_mp_tagged, checked every cycle against a transaction-level model
// (round-robin pick by modular arithmetic, per-port tag counters, a sparse
// word store and a queue of scheduled returns).
module tb_mem_mp_tagged;
  localparam int P       = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TW      = 4;
  localparam int DEPTH   = 16384;
  localparam int LAT     = 4;
  localparam int TAG_MAX = (1 << TW) - 1;
  localparam int BE_W    = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_mp_tagged_if #(.NUM_PORTS(P), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) bus ();

  mem_mp_tagged #(
    .NUM_PORTS(P), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW),
    .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Requests each port is currently presenting (held until granted)
  logic [1:0]      req_cmd  [P];
  logic [AW-1:0]   req_addr [P];
  logic [DW-1:0]   req_data [P];
  logic [BE_W-1:0] req_be   [P];

  // Reference model
  typedef struct {
    int          due;
    int          port;
    int          tag;
    logic [DW-1:0] data;
  } ret_t;
  int            rr_m;
  int            tag_m [P];
  logic [DW-1:0] mem_m [int];
  ret_t          ret_q [$];
  int            cyc;

  // Values observed in the most recent step
  int            obs_resp [P];
  int            obs_tag  [P];
  logic [DW-1:0] obs_data [P];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      bus.proc2mem_command[2*p +: 2] = req_cmd[p];
      bus.proc2mem_addr[p*AW +: AW]  = req_addr[p];
      bus.proc2mem_data[p*DW +: DW]  = req_data[p];
`ifdef MEM_BYTE_WRITE_EN
      bus.proc2mem_be[p*BE_W +: BE_W] = req_be[p];
`endif
    end
  endtask

  task automatic sample();
    for (int p = 0; p < P; p++) begin
      obs_resp[p] = int'(bus.mem2proc_response[p*TW +: TW]);
      obs_tag[p]  = int'(bus.mem2proc_tag[p*TW +: TW]);
      obs_data[p] = bus.mem2proc_data[p*DW +: DW];
    end
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    int   grant;
    bit   has_ret;
    ret_t r;
    int   idx;
    logic [DW-1:0] w;
    drive();
    @(negedge clk);
    sample();
    grant = -1;
    for (int i = 0; i < P; i++) begin
      int q;
      q = (rr_m + i) % P;
      if (grant < 0 && (req_cmd[q] == 2'd1 || req_cmd[q] == 2'd2)) grant = q;
    end
    has_ret = (ret_q.size() > 0) && (ret_q[0].due == cyc);
    if (has_ret) r = ret_q.pop_front();
    for (int p = 0; p < P; p++) begin
      chk($sformatf("c%0d resp%0d", cyc, p), 64'(obs_resp[p]), 64'((p == grant) ? tag_m[p] : 0));
      chk($sformatf("c%0d tag%0d", cyc, p), 64'(obs_tag[p]), 64'((has_ret && r.port == p) ? r.tag : 0));
      chk($sformatf("c%0d data%0d", cyc, p), 64'(obs_data[p]), 64'((has_ret && r.port == p) ? r.data : '0));
    end
    $display("cycle %0d: grant=%0d resp=%0d/%0d ret_tag=%0d/%0d", cyc, grant,
             obs_resp[0], obs_resp[1], obs_tag[0], obs_tag[1]);
    if (grant >= 0) begin
      idx = int'((req_addr[grant] >> 2) % DEPTH);
      if (req_cmd[grant] == 2'd1) begin
        ret_q.push_back('{cyc + LAT, grant, tag_m[grant], mem_m[idx]});
      end else begin
        w = mem_m.exists(idx) ? mem_m[idx] : '0;
        for (int b = 0; b < BE_W; b++) begin
`ifdef MEM_BYTE_WRITE_EN
          if (req_be[grant][b]) w[b*8 +: 8] = req_data[grant][b*8 +: 8];
`else
          w[b*8 +: 8] = req_data[grant][b*8 +: 8];
`endif
        end
        mem_m[idx] = w;
      end
      tag_m[grant] = (tag_m[grant] == TAG_MAX) ? 1 : tag_m[grant] + 1;
      rr_m = (grant + 1) % P;
      req_cmd[grant] = 2'd0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle with rst held low; entered and left at posedge+1.
  task automatic reset_cycle();
    rst = 1'b0;
    drive();
    @(negedge clk);
    sample();
    for (int p = 0; p < P; p++) begin
      chk($sformatf("rst c%0d resp%0d", cyc, p), 64'(obs_resp[p]), 64'd0);
      chk($sformatf("rst c%0d tag%0d", cyc, p), 64'(obs_tag[p]), 64'd0);
      chk($sformatf("rst c%0d data%0d", cyc, p), 64'(obs_data[p]), 64'd0);
    end
    $display("cycle %0d: reset", cyc);
    ret_q.delete();
    rr_m = 0;
    for (int p = 0; p < P; p++) tag_m[p] = 1;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [1:0] c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BE_W-1:0] be);
    req_cmd[p]  = c;
    req_addr[p] = a;
    req_data[p] = d;
    req_be[p]   = be;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc  = 0;
    rr_m = 0;
    for (int p = 0; p < P; p++) begin
      tag_m[p] = 1;
      set_req(p, 2'd0, '0, '0, '1);
    end
    drive();
    @(posedge clk);
    #1;
    reset_cycle();

    // 1: preload, reset (contents survive), single load
    set_req(0, 2'd2, 32'h100, 32'hDEADBEEF, '1);
    step();
    reset_cycle();
    set_req(0, 2'd1, 32'h100, '0, '1);
    step();
    chk("t1 resp0", 64'(obs_resp[0]), 64'd1);
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      if (k == LAT) begin
        chk("t1 tag0", 64'(obs_tag[0]), 64'd1);
        chk("t1 data0", 64'(obs_data[0]), 64'hDEADBEEF);
      end
      if (k == LAT + 1) chk("t1 tag0 after", 64'(obs_tag[0]), 64'd0);
    end

    // 2: contention from rr_ptr=0 alternates P0,P1 with tags 1,2,3 each
    reset_cycle();
    for (int k = 0; k < 6; k++) begin
      set_req(0, 2'd1, 32'h100, '0, '1);
      set_req(1, 2'd1, 32'h100, '0, '1);
      step();
      chk($sformatf("t2 win k%0d", k), 64'(obs_resp[k % 2]), 64'(k / 2 + 1));
      chk($sformatf("t2 stall k%0d", k), 64'(obs_resp[1 - k % 2]), 64'd0);
    end
    for (int p = 0; p < P; p++) req_cmd[p] = 2'd0;
    idle(LAT + 1);

    // 3: store then load same word next cycle on P1
    reset_cycle();
    set_req(1, 2'd2, 32'h200, 32'h12345678, '1);
    step();
    set_req(1, 2'd1, 32'h200, '0, '1);
    step();
    chk("t3 resp1", 64'(obs_resp[1]), 64'd2);
    idle(LAT - 1);
    step();
    chk("t3 tag1", 64'(obs_tag[1]), 64'd2);
    chk("t3 data1", 64'(obs_data[1]), 64'h12345678);
    idle(2);

    // 4: tag wrap 1..15 then 1
    reset_cycle();
    for (int k = 0; k < 16; k++) begin
      set_req(0, 2'd1, 32'h100, '0, '1);
      step();
      chk($sformatf("t4 tag k%0d", k), 64'(obs_resp[0]), 64'((k % TAG_MAX) + 1));
    end
    idle(LAT + 1);

    // 5: reset with three loads in flight
    for (int k = 0; k < 3; k++) begin
      set_req(0, 2'd1, 32'h100, '0, '1);
      step();
    end
    reset_cycle();
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      chk($sformatf("t5 dropped k%0d", k), 64'(obs_tag[0]), 64'd0);
    end
    set_req(0, 2'd1, 32'h100, '0, '1);
    set_req(1, 2'd1, 32'h200, '0, '1);
    step();
    chk("t5 first resp0", 64'(obs_resp[0]), 64'd1);
    chk("t5 first resp1", 64'(obs_resp[1]), 64'd0);
    step();
    chk("t5 second resp1", 64'(obs_resp[1]), 64'd1);
    idle(LAT + 1);

`ifdef MEM_BYTE_WRITE_EN
    // 6: byte-lane stores, including an all-zero enable
    set_req(0, 2'd2, 32'h300, 32'hAABBCCDD, 4'hF);
    step();
    set_req(0, 2'd2, 32'h300, 32'h11223344, 4'b0101);
    step();
    set_req(0, 2'd2, 32'h300, 32'h55667788, 4'b0000);
    step();
    set_req(0, 2'd1, 32'h300, '0, '1);
    step();
    idle(LAT - 1);
    step();
    chk("t6 be data", 64'(obs_data[0]), 64'hAA22CC44);
    idle(1);
`endif

    // Random traffic over 16 words with random upper/low address bits
    for (int wd = 0; wd < 16; wd++) begin
      set_req(0, 2'd2, AW'(wd * 4), DW'($urandom), '1);
      step();
    end
    for (int it = 0; it < 400; it++) begin
      if (it == 200) reset_cycle();
      for (int p = 0; p < P; p++) begin
        if (req_cmd[p] != 2'd1 && req_cmd[p] != 2'd2) begin
          set_req(p, 2'($urandom_range(0, 3)),
                  (AW'($urandom) & ~AW'(32'hFFFC)) | AW'($urandom_range(0, 15) << 2),
                  DW'($urandom), BE_W'($urandom));
        end
      end
      step();
    end
    for (int p = 0; p < P; p++) req_cmd[p] = 2'd0;
    idle(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
